// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared screen/paddle geometry and ball state enumeration
package pong_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int PADDLE_W  = 8;
    localparam int PADDLE_H  = 64;
    localparam int PADDLE1_X = 16;
    localparam int PADDLE2_X = 616;

    typedef enum logic {
        SERVE = 1'b0,
        PLAY  = 1'b1
    } ball_state_t;

endpackage

// File: rtl/serve_timer.sv
// rtl/serve_timer.sv - counts frame ticks while enabled, pulses done on the final one
module serve_timer #(
    parameter int FRAMES = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic tick,
    output logic done
);

    localparam int CW = $clog2(FRAMES + 1);

    logic [CW-1:0] count;

    assign done = en && tick && (count == CW'(FRAMES - 1));

    // Count is held at zero whenever disabled so every serve starts fresh.
    always_ff @(posedge clk) begin
        if (rst || !en || done) begin
            count <= '0;
        end else if (tick) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/ball_physics.sv
// rtl/ball_physics.sv - ball motion, wall bounce, paddle collision and scoring
module ball_physics import pong_pkg::*; #(
    parameter int BALL_SIZE    = 8,
    parameter int SPEED        = 2,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [9:0] paddle1_ypos,
    input  logic [9:0] paddle2_ypos,
    output logic [9:0] ball_xpos,
    output logic [9:0] ball_ypos,
    output logic       p1_point,
    output logic       p2_point,
    output logic       serving
);

    localparam logic [9:0]        CENTRE_X = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]        CENTRE_Y = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic signed [10:0] SPD     = 11'(SPEED);
    localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [10:0] Y_MAX   = 11'(SCREEN_H - BALL_SIZE);
    localparam logic signed [10:0] P1_EDGE = 11'(PADDLE1_X + PADDLE_W);
    localparam logic signed [10:0] P2_EDGE = 11'(PADDLE2_X - BALL_SIZE);
    localparam logic [10:0]        BSZ_U   = 11'(BALL_SIZE);
    localparam logic [10:0]        PH_U    = 11'(PADDLE_H);

    ball_state_t state, state_d;
    logic [9:0]  ball_x, ball_y, x_d, y_d;
    logic        dx, dy, dx_d, dy_d;
    logic        p1_d, p2_d;
    logic        serve_done;

    logic signed [10:0] xs, ys, nx, ny;
    logic [10:0]        y_u, p1_u, p2_u;
    logic               ov1, ov2, hit_l, hit_r;

    serve_timer #(.FRAMES(SERVE_FRAMES)) u_serve_timer (
        .clk  (clk_0),
        .rst  (rst),
        .en   (state == SERVE),
        .tick (frame_tick),
        .done (serve_done)
    );

    // dx/dy: 1 means moving toward larger coordinates.
    always_comb begin
        xs    = signed'({1'b0, ball_x});
        ys    = signed'({1'b0, ball_y});
        nx    = dx ? xs + SPD : xs - SPD;
        ny    = dy ? ys + SPD : ys - SPD;
        y_u   = {1'b0, ball_y};
        p1_u  = {1'b0, paddle1_ypos};
        p2_u  = {1'b0, paddle2_ypos};
        ov1   = (y_u + BSZ_U > p1_u) && (y_u < p1_u + PH_U);
        ov2   = (y_u + BSZ_U > p2_u) && (y_u < p2_u + PH_U);
        hit_l = !dx && (nx <= P1_EDGE) && (xs >= P1_EDGE) && ov1;
        hit_r = dx && (nx >= P2_EDGE) && (xs <= P2_EDGE) && ov2;
    end

    always_comb begin
        state_d = state;
        x_d     = ball_x;
        y_d     = ball_y;
        dx_d    = dx;
        dy_d    = dy;
        p1_d    = 1'b0;
        p2_d    = 1'b0;
        case (state)
            SERVE: begin
                if (serve_done) state_d = PLAY;
            end
            PLAY: begin
                if (frame_tick) begin
                    if (ny <= 11'sd0) begin
                        y_d  = 10'd0;
                        dy_d = 1'b1;
                    end else if (ny >= Y_MAX) begin
                        y_d  = Y_MAX[9:0];
                        dy_d = 1'b0;
                    end else begin
                        y_d  = ny[9:0];
                    end

                    if (hit_l) begin
                        x_d  = P1_EDGE[9:0];
                        dx_d = 1'b1;
                    end else if (hit_r) begin
                        x_d  = P2_EDGE[9:0];
                        dx_d = 1'b0;
                    end else if (!dx && nx <= 11'sd0) begin
                        // Serve heads back toward the player who conceded.
                        state_d = SERVE;
                        x_d     = CENTRE_X;
                        y_d     = CENTRE_Y;
                        dx_d    = 1'b0;
                        p2_d    = 1'b1;
                    end else if (nx >= X_MAX) begin
                        state_d = SERVE;
                        x_d     = CENTRE_X;
                        y_d     = CENTRE_Y;
                        dx_d    = 1'b1;
                        p1_d    = 1'b1;
                    end else begin
                        x_d = nx[9:0];
                    end
                end
            end
            default: state_d = SERVE;
        endcase
    end

    always_ff @(posedge clk_0) begin
        if (rst) begin
            state    <= SERVE;
            ball_x   <= CENTRE_X;
            ball_y   <= CENTRE_Y;
            dx       <= 1'b1;
            dy       <= 1'b1;
            p1_point <= 1'b0;
            p2_point <= 1'b0;
        end else begin
            state    <= state_d;
            ball_x   <= x_d;
            ball_y   <= y_d;
            dx       <= dx_d;
            dy       <= dy_d;
            p1_point <= p1_d;
            p2_point <= p2_d;
        end
    end

    assign ball_xpos = ball_x;
    assign ball_ypos = ball_y;
    assign serving   = (state == SERVE);

endmodule

// File: tb/tb_ball_physics.sv
// tb/tb_ball_physics.sv - directed self-checking bench for ball_physics
module tb_ball_physics;

    logic       clk_0 = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] paddle1_ypos = 10'd0;
    logic [9:0] paddle2_ypos = 10'd0;
    logic [9:0] ball_xpos, ball_ypos;
    logic       p1_point, p2_point, serving;

    int n_checks = 0;
    int n_fail   = 0;

    ball_physics dut (
        .clk_0        (clk_0),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .paddle1_ypos (paddle1_ypos),
        .paddle2_ypos (paddle2_ypos),
        .ball_xpos    (ball_xpos),
        .ball_ypos    (ball_ypos),
        .p1_point     (p1_point),
        .p2_point     (p2_point),
        .serving      (serving)
    );

    always #5 clk_0 = ~clk_0;

    task automatic do_tick();
        @(negedge clk_0) frame_tick = 1'b1;
        @(negedge clk_0) frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_0) rst = 1'b1;
        @(negedge clk_0) rst = 1'b0;
    endtask

    task automatic place(input logic [9:0] x, input logic [9:0] y, input logic dxv, input logic dyv);
        @(negedge clk_0);
        dut.ball_x = x;
        dut.ball_y = y;
        dut.dx     = dxv;
        dut.dy     = dyv;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (serving !== 1'b1) begin n_fail++; $display("FAIL reset_serving: got %0b want 1", serving); end
        n_checks++;
        if (ball_xpos !== 10'd316 || ball_ypos !== 10'd236) begin
            n_fail++; $display("FAIL reset_pos: got (%0d,%0d) want (316,236)", ball_xpos, ball_ypos);
        end
        n_checks++;
        if (p1_point !== 1'b0 || p2_point !== 1'b0) begin
            n_fail++; $display("FAIL reset_points: got p1=%0b p2=%0b want 0 0", p1_point, p2_point);
        end
    endtask

    task automatic test_serve();
        repeat (59) do_tick();
        n_checks++;
        if (serving !== 1'b1) begin n_fail++; $display("FAIL serve_tick59: serving %0b want 1", serving); end
        do_tick();
        n_checks++;
        if (serving !== 1'b0 || ball_xpos !== 10'd316 || ball_ypos !== 10'd236) begin
            n_fail++; $display("FAIL serve_tick60: serving=%0b pos (%0d,%0d) want 0 (316,236)", serving, ball_xpos, ball_ypos);
        end
        repeat (3) @(negedge clk_0);
        n_checks++;
        if (ball_xpos !== 10'd316) begin n_fail++; $display("FAIL hold_between_ticks: x %0d want 316", ball_xpos); end
        do_tick();
        n_checks++;
        if (ball_xpos !== 10'd318 || ball_ypos !== 10'd238) begin
            n_fail++; $display("FAIL first_play: got (%0d,%0d) want (318,238)", ball_xpos, ball_ypos);
        end
    endtask

    task automatic test_vert_bounce();
        place(10'd300, 10'd471, 1'b1, 1'b1);
        do_tick();
        n_checks++;
        if (ball_ypos !== 10'd472 || ball_xpos !== 10'd302) begin
            n_fail++; $display("FAIL bottom_clamp: got (%0d,%0d) want (302,472)", ball_xpos, ball_ypos);
        end
        do_tick();
        n_checks++;
        if (ball_ypos !== 10'd470 || ball_xpos !== 10'd304) begin
            n_fail++; $display("FAIL bottom_reverse: got (%0d,%0d) want (304,470)", ball_xpos, ball_ypos);
        end
    endtask

    task automatic test_left_hit();
        paddle1_ypos = 10'd200;
        place(10'd25, 10'd220, 1'b0, 1'b1);
        do_tick();
        n_checks++;
        if (ball_xpos !== 10'd24 || ball_ypos !== 10'd222) begin
            n_fail++; $display("FAIL left_hit_pos: got (%0d,%0d) want (24,222)", ball_xpos, ball_ypos);
        end
        n_checks++;
        if (p1_point !== 1'b0 || p2_point !== 1'b0 || serving !== 1'b0) begin
            n_fail++; $display("FAIL left_hit_flags: p1=%0b p2=%0b serving=%0b want 0 0 0", p1_point, p2_point, serving);
        end
        do_tick();
        n_checks++;
        if (ball_xpos !== 10'd26) begin n_fail++; $display("FAIL left_hit_dx: x %0d want 26", ball_xpos); end
    endtask

    task automatic test_left_miss();
        paddle1_ypos = 10'd0;
        place(10'd2, 10'd300, 1'b0, 1'b1);
        do_tick();
        n_checks++;
        if (p2_point !== 1'b1 || p1_point !== 1'b0) begin
            n_fail++; $display("FAIL miss_pulse: p1=%0b p2=%0b want 0 1", p1_point, p2_point);
        end
        n_checks++;
        if (serving !== 1'b1 || ball_xpos !== 10'd316 || ball_ypos !== 10'd236) begin
            n_fail++; $display("FAIL miss_recentre: serving=%0b pos (%0d,%0d) want 1 (316,236)", serving, ball_xpos, ball_ypos);
        end
        @(negedge clk_0);
        n_checks++;
        if (p2_point !== 1'b0) begin n_fail++; $display("FAIL miss_pulse_width: p2 %0b want 0", p2_point); end
        repeat (60) do_tick();
        n_checks++;
        if (serving !== 1'b0) begin n_fail++; $display("FAIL miss_reserve: serving %0b want 0", serving); end
        do_tick();
        n_checks++;
        if (ball_xpos !== 10'd314 || ball_ypos !== 10'd238) begin
            n_fail++; $display("FAIL miss_serve_dir: got (%0d,%0d) want (314,238)", ball_xpos, ball_ypos);
        end
    endtask

    task automatic test_corner();
        paddle2_ypos = 10'd440;
        place(10'd607, 10'd471, 1'b1, 1'b1);
        do_tick();
        n_checks++;
        if (ball_xpos !== 10'd608 || ball_ypos !== 10'd472) begin
            n_fail++; $display("FAIL corner_pos: got (%0d,%0d) want (608,472)", ball_xpos, ball_ypos);
        end
        n_checks++;
        if (p1_point !== 1'b0 || p2_point !== 1'b0) begin
            n_fail++; $display("FAIL corner_points: p1=%0b p2=%0b want 0 0", p1_point, p2_point);
        end
        do_tick();
        n_checks++;
        if (ball_xpos !== 10'd606 || ball_ypos !== 10'd470) begin
            n_fail++; $display("FAIL corner_dirs: got (%0d,%0d) want (606,470)", ball_xpos, ball_ypos);
        end
    endtask

    task automatic test_reset_vs_miss();
        paddle1_ypos = 10'd0;
        place(10'd2, 10'd300, 1'b0, 1'b1);
        @(negedge clk_0);
        frame_tick = 1'b1;
        rst        = 1'b1;
        @(negedge clk_0);
        frame_tick = 1'b0;
        rst        = 1'b0;
        n_checks++;
        if (p1_point !== 1'b0 || p2_point !== 1'b0) begin
            n_fail++; $display("FAIL rst_miss_points: p1=%0b p2=%0b want 0 0", p1_point, p2_point);
        end
        n_checks++;
        if (serving !== 1'b1 || ball_xpos !== 10'd316 || ball_ypos !== 10'd236) begin
            n_fail++; $display("FAIL rst_miss_state: serving=%0b pos (%0d,%0d) want 1 (316,236)", serving, ball_xpos, ball_ypos);
        end
        repeat (61) do_tick();
        n_checks++;
        if (ball_xpos !== 10'd318 || ball_ypos !== 10'd238) begin
            n_fail++; $display("FAIL rst_miss_dirs: got (%0d,%0d) want (318,238)", ball_xpos, ball_ypos);
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_vert_bounce();
        test_left_hit();
        test_left_miss();
        test_corner();
        test_reset_vs_miss();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_physics.md
BALL_PHYSICS -- requirements
Module: ball_physics

Interface
REQ-001 The module SHALL have parameter BALL_SIZE, default 8, meaning the ball square edge in pixels.
REQ-002 The module SHALL have parameter SPEED, default 2, meaning pixels moved per axis per frame.
REQ-003 The module SHALL have parameter SERVE_FRAMES, default 60, meaning frames the ball is held centred before launch.
REQ-004 The module SHALL take its screen and paddle geometry from package constants: SCREEN_W=640, SCREEN_H=480, PADDLE_W=8, PADDLE_H=64, PADDLE1_X=16, PADDLE2_X=616.
REQ-005 The module SHALL have port clk_0, input, 1 bit: the 25.175MHz pixel clock; the single clock domain.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have port frame_tick, input, 1 bit: a one-cycle pulse per frame, at the start of vertical blanking.
REQ-008 The module SHALL have ports paddle1_ypos and paddle2_ypos, input, 10 bits each: the paddle top edges.
REQ-009 The module SHALL have ports ball_xpos and ball_ypos, output, 10 bits each: the ball top-left corner.
REQ-010 The module SHALL have ports p1_point and p2_point, output, 1 bit each: a one-cycle pulse when that player scores.
REQ-011 The module SHALL have port serving, output, 1 bit: high while the ball is held centred.

Function
REQ-012 The module SHALL use states SERVE and PLAY.
REQ-013 In SERVE, ball_xpos SHALL be 316 and ball_ypos SHALL be 236 (centred for BALL_SIZE=8), and serving SHALL be 1.
REQ-014 In SERVE, the module SHALL count frame_tick pulses; the tick that makes the count equal SERVE_FRAMES SHALL move the state to PLAY, clear the count, and leave the position unchanged on that tick.
REQ-015 In PLAY, each frame_tick SHALL update the ball position, with the new position visible on the cycle after the tick; the position SHALL hold between ticks.
REQ-016 Next-position arithmetic SHALL be 11-bit signed: nx = x ± SPEED and ny = y ± SPEED, so that underflow below 0 is detectable.
REQ-017 Vertical bounce: if ny <= 0, then y SHALL be set to 0 and dy SHALL become +; if ny >= SCREEN_H-BALL_SIZE, then y SHALL be set to 472 and dy SHALL become -.
REQ-018 A left paddle hit SHALL occur when dx is -, nx <= PADDLE1_X+PADDLE_W, x >= PADDLE1_X+PADDLE_W, and the current y overlaps paddle1 (y+BALL_SIZE > paddle1_ypos and y < paddle1_ypos+PADDLE_H); on a hit, x SHALL be set to 24 and dx SHALL become +.
REQ-019 A right paddle hit SHALL be the mirror of REQ-018: dx is +, nx+BALL_SIZE >= PADDLE2_X, and y overlaps paddle2; on a hit, x SHALL be set to 608 and dx SHALL become -.
REQ-020 A left miss SHALL occur when dx is - and nx <= 0 without a hit: p2_point SHALL pulse one cycle, the state SHALL become SERVE, and dx SHALL become - (serve toward the conceding player).
REQ-021 A right miss SHALL occur when nx >= SCREEN_W-BALL_SIZE without a hit: p1_point SHALL pulse, the state SHALL become SERVE, and dx SHALL become +.
REQ-022 Vertical and horizontal rules SHALL be evaluated independently on the same tick; a corner case SHALL apply both.
REQ-023 Overlap SHALL use the paddle positions sampled on the tick cycle.
REQ-024 p1_point and p2_point SHALL never be high in the same cycle, and SHALL never be high outside the cycle after a tick.
REQ-025 In PLAY, frame_tick SHALL be the only event that changes position or state.

Reset
REQ-026 When rst=1, on the next clk_0 edge the module SHALL enter SERVE, clear the serve count, and set dx=+, dy=+, ball to (316,236), p1_point=0, p2_point=0, serving=1.
REQ-027 rst SHALL take priority over a coincident frame_tick; reset mid-PLAY SHALL discard any pending point pulse.

Structure
REQ-028 Package pong_pkg SHALL hold SCREEN_W, SCREEN_H, PADDLE_W, PADDLE_H, PADDLE1_X, PADDLE2_X, and the state enumeration, shared with pong_renderer and the paddle logic.
REQ-029 One sub-module, serve_timer (a frame-tick counter with a done pulse), is natural; collision logic SHALL stay in ball_physics.

Verification
REQ-030 Bench: reset, then 60 frame_ticks -> serving falls after tick 60; the first PLAY tick gives (318,238).
REQ-031 Bench: ball at y=471 with dy=+ -> after a tick, y=472 and dy=-; the next tick gives y=470.
REQ-032 Bench: paddle1_ypos=200, ball (25,220) with dx=- -> after a tick, x=24 and dx=+; no point pulse.
REQ-033 Bench: paddle1_ypos=0, ball (2,300) with dx=- -> after a tick, p2_point pulses for exactly 1 cycle, serving=1, ball=(316,236); after 60 ticks the ball moves left.
REQ-034 Bench: ball at corner (607,471) with paddle2 covering it -> after a tick, x=608, y=472, dx=-, dy=-.
REQ-035 Bench: rst asserted together with the tick that causes a miss -> no point pulse, and reset state per REQ-026.
